// File: rtl/hamming_enc_arbiter.sv
// Round-robin front end that time-shares one registered Hamming(7,4) encoder
// among NREQ requesters, returning each checked codeword tagged with its source.
module hamming_enc_arbiter #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16,
  localparam int ID_W = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              enc_en,
  output logic [3:0]        enc_data,
  input  logic [6:0]        enc_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_code,
  output logic [ID_W-1:0]   out_id,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              enc_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t           r_state, w_next;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_out_id;
  logic [3:0]       r_hold_data;
  logic [6:0]       r_out_code;
  logic [CNT_W-1:0] r_word_cnt;
  logic             r_enc_err;

  logic             w_found;
  logic [ID_W-1:0]  w_win;
  logic             w_req_hs;
  logic             w_out_hs;
  logic [2:0]       w_syn;
  logic             w_bad;
  logic [ID_W-1:0]  w_rr_next;

  // Scan from rr_ptr upward, wrapping at NREQ; first pending requester wins.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  assign req_ready = (r_state == IDLE && w_found) ? (NREQ'(1) << w_win) : '0;
  assign w_req_hs  = (r_state == IDLE) && w_found;
  assign w_out_hs  = (r_state == OUT) && out_ready;

  assign w_syn = {enc_code[3] ^ enc_code[4] ^ enc_code[5] ^ enc_code[6],
                  enc_code[1] ^ enc_code[2] ^ enc_code[5] ^ enc_code[6],
                  enc_code[0] ^ enc_code[2] ^ enc_code[4] ^ enc_code[6]};
  assign w_bad = (w_syn != 3'b000) ||
                 ({enc_code[6], enc_code[5], enc_code[4], enc_code[2]} != r_hold_data);

  assign w_rr_next = (r_out_id == ID_W'(NREQ - 1)) ? '0 : r_out_id + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_req_hs) w_next = ISSUE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = OUT;
      OUT:     if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_out_id    <= '0;
      r_hold_data <= '0;
      r_out_code  <= '0;
      r_word_cnt  <= '0;
      r_enc_err   <= 1'b0;
    end else begin
      if (w_req_hs) begin
        r_hold_data <= req_data[4*w_win +: 4];
        r_out_id    <= w_win;
      end
      if (r_state == WAIT) begin
        r_out_code <= enc_code;
        if (w_bad) r_enc_err <= 1'b1;
      end
      if (w_out_hs) begin
        r_word_cnt <= r_word_cnt + 1'b1;
        r_rr_ptr   <= w_rr_next;
      end
    end
  end

  // hold_data is only reloaded at a grant, so enc_data stays put through WAIT.
  assign enc_en    = (r_state == ISSUE);
  assign enc_data  = r_hold_data;
  assign out_valid = (r_state == OUT);
  assign out_code  = r_out_code;
  assign out_id    = r_out_id;
  assign word_cnt  = r_word_cnt;
  assign enc_err   = r_enc_err;

endmodule

// File: tb/tb_hamming_enc_arbiter.sv
// Scoreboard bench: a grant-level model predicts each word; a monitor checks outputs.
module tb_hamming_enc_arbiter;
  localparam int NREQ  = 4;
  localparam int CNT_W = 8;  // narrow counter so the wrap is reachable quickly

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [4*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              enc_en;
  logic [3:0]        enc_data;
  logic [6:0]        enc_code;
  logic              out_valid;
  logic              out_ready;
  logic [6:0]        out_code;
  logic [1:0]        out_id;
  logic [CNT_W-1:0]  word_cnt;
  logic              enc_err;

  hamming_enc_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .enc_en(enc_en), .enc_data(enc_data),
    .enc_code(enc_code), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_id(out_id), .word_cnt(word_cnt), .enc_err(enc_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [6:0] code;
  } item_t;

  item_t q[$];
  int    nvec = 0;
  int    nfail = 0;
  int    n_done = 0;
  bit    fault_arm = 1'b0;

  // model state
  bit         m_busy = 1'b0;
  int         m_age = 0;
  int         m_rr = 0;
  int         m_id = 0;
  int         m_cnt = 0;
  bit         m_fault = 1'b0;
  bit         m_err = 1'b0;
  logic [3:0] m_data = 4'h0;

  function automatic logic [6:0] enc7(logic [3:0] d);
    return {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // encoder stand-in: registered, updates on the edge that samples enc_en
  always @(posedge clk or posedge rst) begin
    if (rst)         enc_code <= 7'h00;
    else if (enc_en) enc_code <= enc7(enc_data) ^ (fault_arm ? 7'h08 : 7'h00);
  end

  // model / stimulus-side checker
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_rdy;
    int w;
    exp_rdy = '0;
    w = 0;
    if (!rst) begin
      if (m_busy) begin
        m_age++;
        if (m_age == 3 && m_fault) m_err = 1'b1;
      end else begin
        for (int k = NREQ - 1; k >= 0; k--)
          if (req_valid[(m_rr + k) % NREQ]) w = (m_rr + k) % NREQ;
        if (req_valid != '0) exp_rdy[w] = 1'b1;
      end
      chk("req_ready", req_ready, exp_rdy);
      chk("enc_en", enc_en, m_busy && m_age == 1);
      if (m_busy && (m_age == 1 || m_age == 2)) chk("enc_data", enc_data, m_data);
      chk("out_valid", out_valid, m_busy && m_age >= 3);
      chk("word_cnt", word_cnt, m_cnt);
      chk("enc_err", enc_err, m_err);
      if (!m_busy && exp_rdy != '0) begin
        m_busy  = 1'b1;
        m_age   = 0;
        m_id    = w;
        m_data  = req_data[4*w +: 4];
        m_fault = fault_arm;
        q.push_back('{id: w, code: enc7(m_data) ^ (fault_arm ? 7'h08 : 7'h00)});
      end else if (m_busy && m_age >= 3 && out_ready) begin
        m_busy = 1'b0;
        m_rr   = (m_id + 1) % NREQ;
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
      end
    end
  end

  // output monitor
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL out_unexpected: got out_valid=1 expected empty scoreboard at %0t", $time);
      end else begin
        chk("out_code", out_code, q[0].code);
        chk("out_id", out_id, q[0].id);
        if (out_ready) begin
          void'(q.pop_front());
          n_done++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int target, int budget, bit rnd);
    int c = 0;
    while (n_done < target && c < budget) begin
      if (rnd) req_data = 16'($urandom);
      tick();
      c++;
    end
    if (n_done < target) begin
      nfail++;
      $display("FAIL timeout: got %0d completions expected %0d", n_done, target);
    end
  endtask

  task automatic grant_one(int id, logic [3:0] d);
    bit got = 1'b0;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_data[4*id +: 4] = d;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1'b1;
    end
    if (!got) begin
      nfail++;
      $display("FAIL grant_timeout: got no grant expected grant to %0d", id);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
  endtask

  task automatic send_one(int id, logic [3:0] d);
    int t = n_done + 1;
    grant_one(id, d);
    wait_done(t, 50, 1'b0);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_enc_en"}, enc_en, 0);
    chk({tag, "_enc_data"}, enc_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_code"}, out_code, 0);
    chk({tag, "_out_id"}, out_id, 0);
    chk({tag, "_word_cnt"}, word_cnt, 0);
    chk({tag, "_enc_err"}, enc_err, 0);
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_age = 0; m_rr = 0; m_cnt = 0; m_err = 1'b0; m_fault = 1'b0;
    q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int t;
    bit seen;
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    #1;
    check_zero("reset");
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // single word: 1011 -> 1010101 from requester 2
    send_one(2, 4'b1011);
    chk("single_cnt", word_cnt, 1);

    // all 16 data values through random requesters
    for (int v = 0; v < 16; v++) send_one($urandom_range(0, NREQ - 1), 4'(v));

    // round robin with every requester pending
    req_valid = '1;
    wait_done(n_done + 8, 100, 1'b1);
    req_valid = '0;
    repeat (4) tick();

    // back-pressure: ten stalled cycles in OUT
    out_ready = 1'b0;
    t = n_done + 1;
    grant_one(1, 4'($urandom));
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      seen = out_valid;
    end
    chk("bp_out_valid", out_valid, 1);
    repeat (10) tick();
    out_ready = 1'b1;
    wait_done(t, 5, 1'b0);

    // random traffic and random back-pressure
    for (int c = 0; c < 400; c++) begin
      req_valid = NREQ'($urandom);
      req_data  = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && (m_busy || q.size() != 0); c++) tick();
    chk("drain_empty", q.size(), 0);

    // corrupted parity bit on one word, then good words
    fault_arm = 1'b1;
    send_one(0, 4'($urandom));
    fault_arm = 1'b0;
    chk("err_set", enc_err, 1);
    for (int i = 0; i < 3; i++) send_one($urandom_range(0, NREQ - 1), 4'($urandom));
    chk("err_sticky", enc_err, 1);

    // reset while the word sits in WAIT
    grant_one(3, 4'h5);
    tick();
    rst = 1'b1;
    #1;
    check_zero("midrst");
    model_reset();
    tick();
    rst = 1'b0;
    req_valid = '1;
    req_data = 16'($urandom);
    @(negedge clk);
    chk("post_rst_grant", req_ready, 4'b0001);
    @(posedge clk);
    #1;

    // run until the counter wraps
    for (int c = 0; c < 2000 && m_cnt != (1 << CNT_W) - 1; c++) begin
      req_data = 16'($urandom);
      tick();
    end
    chk("pre_wrap", word_cnt, (1 << CNT_W) - 1);
    wait_done(n_done + 1, 10, 1'b1);
    chk("wrap", word_cnt, 0);
    req_valid = '0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/hamming_enc_arbiter.md
# hamming_enc_arbiter

Round-robin scheduler that shares the single Hamming(7,4) encoder among `NREQ` requesters. It accepts 4-bit data words over a valid/ready handshake and drives the encoder's `EN`/`data_in`. It captures the 7-bit codeword one cycle after issue and presents it with the requester ID on a valid/ready output port. It also checks every returned codeword for internal consistency and counts completed words.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, range 2..8.
- `CNT_W`, default 16: width of the completed-word counter.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, NREQ: requester i has a word pending.
- `req_data`, in, 4*NREQ: word of requester i is `req_data[4*i+3:4*i]`.
- `req_ready`, out, NREQ: one-hot grant; the handshake completes when `req_valid[i] & req_ready[i]`.
- `enc_en`, out, 1: drives the encoder `EN`.
- `enc_data`, out, 4: drives the encoder `data_in`.
- `enc_code`, in, 7: encoder `data_out`. It is registered in the encoder and updates on the edge that samples `enc_en=1`.
- `out_valid`, out, 1: codeword available.
- `out_ready`, in, 1: downstream accepts.
- `out_code`, out, 7: captured codeword.
- `out_id`, out, clog2(NREQ), minimum 1 bit: index of the originating requester.
- `word_cnt`, out, CNT_W: number of completed output handshakes.
- `enc_err`, out, 1: sticky flag for an inconsistent codeword.

## Operation
- Codeword layout, bit6..bit0: {d3, d2, d1, p4, d0, p2, p1}.
  - p1 = d0^d1^d3.
  - p2 = d0^d2^d3.
  - p4 = d1^d2^d3.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- **IDLE**
  - Scan `req_valid` starting at `rr_ptr` and increasing modulo NREQ. The first set bit wins.
  - `req_ready` is the one-hot of the winner. It is combinational from `req_valid` and state, and is zero outside IDLE.
  - On the handshake edge:
    - latch the winner's data into `hold_data` and its index into `out_id`;
    - go to ISSUE.
  - With no `req_valid` bit set, stay in IDLE.
- **ISSUE**
  - `enc_en`=1 and `enc_data`=`hold_data` for exactly this cycle.
  - Go to WAIT.
- **WAIT**
  - `enc_en`=0; `enc_data` holds its value.
  - On the exit edge, capture `enc_code` into `out_code`.
  - Consistency check on the captured value:
    - syndrome s1=c0^c2^c4^c6, s2=c1^c2^c5^c6, s4=c3^c4^c5^c6;
    - data check {c6,c5,c4,c2} == `hold_data`.
  - If any syndrome bit is set or the data check fails, set `enc_err`. It is sticky and cleared only by reset.
  - Go to OUT.
- **OUT**
  - `out_valid`=1. `out_code` and `out_id` are stable until the handshake.
  - On `out_ready`:
    - `word_cnt` increments, wrapping from 2^CNT_W-1 to 0;
    - `rr_ptr` becomes (`out_id`+1) mod NREQ;
    - go to IDLE.
- Requesters not granted keep waiting. A requester dropping `req_valid` before it is granted is legal.
- Reset, including mid-transaction:
  - state goes to IDLE, `rr_ptr` to 0;
  - `req_ready`, `enc_en`, `enc_data`, `out_valid`, `out_code`, `out_id`, `word_cnt` and `enc_err` all go to 0;
  - any in-flight word is dropped.

## Timing
- Latency: handshake edge at cycle T. ISSUE runs in cycle T+1, WAIT in T+2, and `out_valid` is high from cycle T+3.
- Maximum throughput is one word per 4 cycles when `out_ready` is held at 1.
- The next grant can occur in the cycle after the output handshake edge.
- `out_valid` is never deasserted without a handshake, and `out_code`/`out_id` do not change while `out_valid`=1.
- `enc_en` is high for exactly one cycle per accepted word and never high outside ISSUE.
- Back-pressure: while `out_ready`=0, the block stays in OUT indefinitely and no new grants are issued.
- The fairness bound with all requesters continuously valid is: a given requester is granted at least once every NREQ transactions.

## Test plan
- **Single word:** requester 2 presents 4'b1011 and `out_ready`=1.
  - Grant at T, `enc_en` pulse at T+1.
  - `out_valid` at T+3 with `out_code`=7'b1010101, `out_id`=2, `word_cnt`=1, `enc_err`=0.
- **Codeword values:** 4'b0000 gives 7'h00 and 4'b1111 gives 7'h7F. Sweep all 16 values against the layout formula; `enc_err` stays 0.
- **Round robin:** all four `req_valid` held high.
  - `out_id` sequence is 0,1,2,3,0.
  - Each `req_ready` is seen exactly once per 4 grants.
  - One word completes every 4 cycles.
- **Back-pressure:** `out_ready`=0 for 10 cycles in OUT.
  - `out_valid` is held with stable code and ID.
  - No `req_ready` or `enc_en` activity during the stall.
  - Completion occurs on the first cycle `out_ready`=1.
- **Encoder fault:** the bench model flips bit 3 of `enc_code` for one word.
  - `enc_err` rises after the WAIT exit edge and stays 1 across later good words until `rst`.
- **Reset mid-operation:** assert `rst` during WAIT.
  - All outputs are 0 immediately.
  - After release, the next grant starts at requester 0 and `word_cnt` restarts from 0.
  - Separately, preload `word_cnt` to 16'hFFFF via traffic; the next completion wraps it to 0.
